// File: rtl/pipe_pkg.sv
// Shared widths, control-bit positions and stage state encodings for pipe_stage_reg.
package pipe_pkg;

  localparam int PIPE_DATA_W = 176;
  localparam int PIPE_CTRL_W = 5;

  localparam int CTRL_MEM_RD = 0;
  localparam int CTRL_MEM_WR = 1;
  localparam int CTRL_WB_EN  = 2;
  localparam int CTRL_B      = 3;
  localparam int CTRL_UPD    = 4;

  // ST_ONE doubles as FULL when the skid entry is not built.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single ctrl+data holding entry with a valid flag; ctrl reads as zero whenever the entry is empty.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and bubble zeroing of ctrl.
// Define PIPE_STAGE_SKID_EN to add one skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  // Handshake: a beat moves on a rising edge where valid && ready on that side;
  // valid never depends on ready, and an unaccepted beat is held unchanged.

  state_t            state_q;
  logic              out_valid_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [DATA_W-1:0] out_data_q;
  logic              in_fire;

  assign in_fire = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_unload;

  // in_ready comes straight from the skid flop, cutting the out_ready -> in_ready path.
  assign in_ready    = !skid_valid;
  assign skid_load   = !flush && (state_q == ST_ONE) && in_fire && !out_ready;
  assign skid_unload = !flush && (state_q == ST_TWO) && out_ready;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (flush),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .ctrl_i   (in_ctrl),
    .data_i   (in_data),
    .valid_o  (skid_valid),
    .ctrl_o   (skid_ctrl),
    .data_o   (skid_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
            out_ctrl_q  <= in_ctrl;
            out_data_q  <= in_data;
          end
        end
        ST_ONE: begin
          if (out_ready) begin
            if (in_fire) begin
              out_ctrl_q <= in_ctrl;
              out_data_q <= in_data;
            end else begin
              state_q     <= ST_EMPTY;
              out_valid_q <= 1'b0;
              out_ctrl_q  <= '0;
            end
          end else if (in_fire) begin
            state_q <= ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            state_q    <= ST_ONE;
            out_ctrl_q <= skid_ctrl;
            out_data_q <= skid_data;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          out_ctrl_q  <= '0;
        end
      endcase
    end
  end
`else
  assign in_ready = !out_valid_q | out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
            out_ctrl_q  <= in_ctrl;
            out_data_q  <= in_data;
          end
        end
        ST_ONE: begin
          if (out_ready) begin
            if (in_fire) begin
              out_ctrl_q <= in_ctrl;
              out_data_q <= in_data;
            end else begin
              // Drain to a bubble: data keeps its last value, ctrl is zeroed.
              state_q     <= ST_EMPTY;
              out_valid_q <= 1'b0;
              out_ctrl_q  <= '0;
            end
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          out_ctrl_q  <= '0;
        end
      endcase
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, hand-written corner sequences and a randomised queue scoreboard.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = PIPE_DATA_W;
  localparam int CW = PIPE_CTRL_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  localparam logic [CW-1:0] C_WB  = CW'(1 << CTRL_WB_EN);
  localparam logic [CW-1:0] C_ALL = CW'((1 << CTRL_MEM_RD) | (1 << CTRL_MEM_WR) | (1 << CTRL_WB_EN) |
                                        (1 << CTRL_B) | (1 << CTRL_UPD));

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [CW+DW-1:0] exp_q[$];

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_ctrl   = c;
    in_data   = d;
  endtask

  task automatic drain();
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    repeat (3) step();
  endtask

  // scoreboard monitor: checks the presented beat, then models the coming edge
  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst) begin
      exp_q.delete();
    end else begin
      chk("sb_out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
      if (!out_valid) begin
        chk("sb_bubble_ctrl", 256'(out_ctrl), 256'(0));
      end else if (exp_q.size() != 0) begin
        chk("sb_out_ctrl", 256'(out_ctrl), 256'(exp_q[0][CW+DW-1:DW]));
        chk("sb_out_data", 256'(out_data), 256'(exp_q[0][DW-1:0]));
      end
`ifdef PIPE_STAGE_SKID_EN
      exp_rdy = (exp_q.size() < CAP);
`else
      exp_rdy = (exp_q.size() == 0) || out_ready;
`endif
      chk("sb_in_ready", 256'(in_ready), 256'(exp_rdy));
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (in_valid && exp_rdy) exp_q.push_back({in_ctrl, in_data});
    end
  end

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          e_valid;
    logic [CW-1:0] e_ctrl;
    logic          chk_data;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [DW-1:0] a_data;
    logic [DW-1:0] b_data;
    logic [DW-1:0] rd;
    int seq;

    vecs[0] = '{1'b1, 1'b1, 1'b0, C_WB,  176'hA1, 1'b1, C_WB,  1'b1, 176'hA1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 5'h03, 176'hB2, 1'b1, 5'h03, 1'b1, 176'hB2};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 5'h00, 176'h0,  1'b1, 5'h03, 1'b1, 176'hB2};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'h00, 176'h0,  1'b0, 5'h00, 1'b1, 176'hB2};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 5'h00, 176'h0,  1'b0, 5'h00, 1'b1, 176'hB2};
    vecs[5] = '{1'b1, 1'b0, 1'b0, C_ALL, 176'hC3, 1'b1, C_ALL, 1'b1, 176'hC3};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 5'h00, 176'h0,  1'b0, 5'h00, 1'b0, 176'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 5'h08, 176'hD4, 1'b0, 5'h00, 1'b0, 176'h0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 5'h10, 176'hE5, 1'b1, 5'h10, 1'b1, 176'hE5};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 5'h00, 176'h0,  1'b0, 5'h00, 1'b1, 176'hE5};

    // 1: reset with a live upstream beat
    drive(1'b1, 1'b1, 1'b0, C_ALL, '1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_ctrl", 256'(out_ctrl), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));

    // vector table
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, vecs[i].data);
      step();
      chk($sformatf("vec%0d_valid", i), 256'(out_valid), 256'(vecs[i].e_valid));
      chk($sformatf("vec%0d_ctrl", i), 256'(out_ctrl), 256'(vecs[i].e_ctrl));
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), 256'(out_data), 256'(vecs[i].e_data));
    end
    drain();

    // 2: streaming, one beat per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, C_WB, DW'(i));
      step();
      chk($sformatf("stream%0d_valid", i), 256'(out_valid), 256'(1));
      chk($sformatf("stream%0d_data", i), 256'(out_data), 256'(i));
    end
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    step();
    chk("stream_end_valid", 256'(out_valid), 256'(0));
    drain();

    // 3: stall with A held, B offered behind it
    a_data = {8{22'h2AAAAA}};
    b_data = {8{22'h155555}};
    drive(1'b1, 1'b0, 1'b0, C_WB, a_data);
    step();
    drive(1'b1, 1'b0, 1'b0, 5'h08, b_data);
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef PIPE_STAGE_SKID_EN
      chk($sformatf("stall%0d_in_ready", i), 256'(in_ready), 256'(i == 0));
`else
      chk($sformatf("stall%0d_in_ready", i), 256'(in_ready), 256'(0));
`endif
      step();
`ifdef PIPE_STAGE_SKID_EN
      in_valid = 1'b0;
`endif
      chk($sformatf("stall%0d_ctrl", i), 256'(out_ctrl), 256'(C_WB));
      chk($sformatf("stall%0d_data", i), 256'(out_data), 256'(a_data));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("stall_b_ctrl", 256'(out_ctrl), 256'(5'h08));
    chk("stall_b_data", 256'(out_data), 256'(b_data));
    step();
    chk("stall_end_valid", 256'(out_valid), 256'(0));
    drain();

    // 4: flush while holding A, B offered in the flush cycle
    drive(1'b1, 1'b0, 1'b0, C_WB, a_data);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'h08, b_data);
    step();
    chk("flush_valid", 256'(out_valid), 256'(0));
    chk("flush_ctrl", 256'(out_ctrl), 256'(0));
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_after%0d_valid", i), 256'(out_valid), 256'(0));
    end

    // 5: bubble after a single beat
    drive(1'b1, 1'b1, 1'b0, C_ALL, b_data);
    step();
    chk("bubble_beat_ctrl", 256'(out_ctrl), 256'(C_ALL));
    in_valid = 1'b0;
    step();
    chk("bubble_valid", 256'(out_valid), 256'(0));
    chk("bubble_ctrl", 256'(out_ctrl), 256'(0));
    chk("bubble_data", 256'(out_data), 256'(b_data));

    // reset asserted mid-transfer
    drive(1'b1, 1'b0, 1'b0, C_ALL, a_data);
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 256'(out_valid), 256'(0));
    chk("midrst_ctrl", 256'(out_ctrl), 256'(0));
    chk("midrst_data", 256'(out_data), 256'(0));
    step();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 256'(in_ready), 256'(1));

    // 6: random traffic against the scoreboard
    seq = 0;
    for (int i = 0; i < 10000; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom, 16'(seq)};
      seq++;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            CW'($urandom_range(0, 31)), rd);
      step();
    end
    drain();
    chk("final_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
